// File: rtl/irq_controller_pkg.sv
// Shared constants for the interrupt controller: register offsets, command/status bit positions, default sizing.
package irq_ctrl_pkg;
  localparam int DEF_N_IRQ = 6;
  localparam int DEF_ID_W  = 3;

  localparam logic [2:0] OFF_MASK  = 3'd0;
  localparam logic [2:0] OFF_MODE  = 3'd1;
  localparam logic [2:0] OFF_PEND  = 3'd2;
  localparam logic [2:0] OFF_VEC   = 3'd3;
  localparam logic [2:0] OFF_INSVC = 3'd4;

  localparam int CMD_CLAIM_BIT = 31;
  localparam int VALID_BIT     = 31;
endpackage

// File: rtl/irq_controller_if.sv
// SouthBridge register bus seen by the interrupt controller; reads are combinational, writes take effect on the WE edge.
interface irq_controller_if;
  logic [7:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/irq_controller_prio_enc.sv
// Fixed-priority encoder: index of the lowest set bit plus a valid flag. Purely combinational.
module irq_prio_enc #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_vld
);
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    // Scan high to low so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = W'(i);
        o_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/irq_controller.sv
// Programmable interrupt controller: mask/mode/pending per line, in-service nesting, fixed priority (line 0 highest).
// IRQ rise to HWInt is two edges; register writes reach HWInt one edge after the write edge.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = DEF_N_IRQ,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic             clk,
  input  logic             reset,
  irq_controller_if.slave  bus,
  input  logic [N_IRQ-1:0] IRQ,
  output logic [N_IRQ-1:0] HWInt
);
  localparam logic [N_IRQ-1:0] ONE = {{(N_IRQ-1){1'b0}}, 1'b1};

  logic [N_IRQ-1:0] r_mask, r_mode, r_pend, r_insvc, r_irq_q;

  logic [2:0]       w_off;
  logic             w_wr_mask, w_wr_mode, w_wr_pend, w_wr_vec;
  logic             w_claim_hit, w_eoi_hit;
  logic [ID_W-1:0]  w_eoi_id;
  logic [ID_W-1:0]  w_ins_idx, w_vec_id, w_ceil;
  logic             w_ins_vld, w_vec_vld;
  logic [N_IRQ-1:0] w_elig, w_clr, w_to_edge, w_pend_nxt;
  logic [N_IRQ-1:0] w_insvc_set, w_insvc_clr;
  logic [31:0]      w_dout;
  logic             w_unused;

  assign w_off     = bus.Addr[4:2];
  assign w_wr_mask = bus.WE && (w_off == OFF_MASK);
  assign w_wr_mode = bus.WE && (w_off == OFF_MODE);
  assign w_wr_pend = bus.WE && (w_off == OFF_PEND);
  assign w_wr_vec  = bus.WE && (w_off == OFF_VEC);
  assign w_eoi_id  = bus.Din[ID_W-1:0];

  irq_prio_enc #(.N(N_IRQ), .W(ID_W)) u_ceil (
    .i_vec (r_insvc),
    .o_idx (w_ins_idx),
    .o_vld (w_ins_vld)
  );

  assign w_ceil = w_ins_vld ? w_ins_idx : ID_W'(N_IRQ);

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      w_elig[i] = r_mask[i] & r_pend[i] & (ID_W'(i) < w_ceil);
    end
  end

  irq_prio_enc #(.N(N_IRQ), .W(ID_W)) u_vec (
    .i_vec (w_elig),
    .o_idx (w_vec_id),
    .o_vld (w_vec_vld)
  );

  assign w_claim_hit = w_wr_vec && bus.Din[CMD_CLAIM_BIT] && w_vec_vld;
  assign w_eoi_hit   = w_wr_vec && !bus.Din[CMD_CLAIM_BIT] && (w_eoi_id < ID_W'(N_IRQ));

  // Edge lines: a new rise beats any clear landing on the same edge.
  assign w_clr      = ({N_IRQ{w_wr_pend}} & bus.Din[N_IRQ-1:0])
                    | (w_claim_hit ? (ONE << w_vec_id) : '0);
  assign w_to_edge  = {N_IRQ{w_wr_mode}} & bus.Din[N_IRQ-1:0] & ~r_mode;
  assign w_pend_nxt = ((r_mode & ((IRQ & ~r_irq_q) | (r_pend & ~w_clr)))
                    | (~r_mode & IRQ)) & ~w_to_edge;

  assign w_insvc_set = w_claim_hit ? (ONE << w_vec_id) : '0;
  assign w_insvc_clr = w_eoi_hit ? (ONE << w_eoi_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask  <= '0;
      r_mode  <= '0;
      r_pend  <= '0;
      r_insvc <= '0;
      r_irq_q <= '0;
      HWInt   <= '0;
    end else begin
      if (w_wr_mask) r_mask <= bus.Din[N_IRQ-1:0];
      if (w_wr_mode) r_mode <= bus.Din[N_IRQ-1:0];
      r_pend  <= w_pend_nxt;
      r_insvc <= (r_insvc | w_insvc_set) & ~w_insvc_clr;
      r_irq_q <= IRQ;
      HWInt   <= w_elig;
    end
  end

  always_comb begin
    w_dout = '0;
    case (w_off)
      OFF_MASK:  w_dout[N_IRQ-1:0] = r_mask;
      OFF_MODE:  w_dout[N_IRQ-1:0] = r_mode;
      OFF_PEND:  w_dout[N_IRQ-1:0] = r_pend;
      OFF_VEC: begin
        w_dout[VALID_BIT] = w_vec_vld;
        w_dout[ID_W-1:0]  = w_vec_id;
      end
      OFF_INSVC: w_dout[N_IRQ-1:0] = r_insvc;
      default:   w_dout = '0;
    endcase
  end

  assign bus.Dout = w_dout;

  assign w_unused = ^{bus.Addr[7:5], bus.Addr[1:0], bus.Din[30:N_IRQ]};
endmodule

// File: tb/tb_irq_controller.sv
// Directed scenarios followed by randomized traffic, checked against a behavioural model of the controller.
module tb_irq_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] IRQ;
  logic [5:0] HWInt;

  int checks = 0;
  int errors = 0;

  irq_controller_if bus_if ();

  irq_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .IRQ   (IRQ),
    .HWInt (HWInt)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [5:0] m_mask = '0, m_mode = '0, m_pend = '0, m_insvc = '0, m_irqq = '0, m_hw = '0;

  function automatic logic [5:0] m_elig();
    int ceil;
    logic [5:0] e;
    ceil = 6;
    for (int i = 5; i >= 0; i--) if (m_insvc[i]) ceil = i;
    e = '0;
    for (int i = 0; i < 6; i++) if (m_mask[i] && m_pend[i] && i < ceil) e[i] = 1'b1;
    return e;
  endfunction

  function automatic int m_vec_id(input logic [5:0] e);
    for (int i = 0; i < 6; i++) if (e[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int id;
    case (a[4:2])
      3'd0: return {26'd0, m_mask};
      3'd1: return {26'd0, m_mode};
      3'd2: return {26'd0, m_pend};
      3'd3: begin
        id = m_vec_id(m_elig());
        return (id >= 0) ? (32'h8000_0000 | 32'(id)) : 32'd0;
      end
      3'd4: return {26'd0, m_insvc};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [5:0] e, np;
    int vid, eid;
    logic [2:0] off;
    logic claim, eoi;
    if (reset) begin
      m_mask = '0; m_mode = '0; m_pend = '0; m_insvc = '0; m_irqq = '0; m_hw = '0;
      return;
    end
    e     = m_elig();
    vid   = m_vec_id(e);
    off   = bus_if.Addr[4:2];
    claim = bus_if.WE && off == 3'd3 && bus_if.Din[31];
    eoi   = bus_if.WE && off == 3'd3 && !bus_if.Din[31];
    for (int i = 0; i < 6; i++) begin
      if (m_mode[i]) begin
        if (IRQ[i] && !m_irqq[i]) np[i] = 1'b1;
        else if ((bus_if.WE && off == 3'd2 && bus_if.Din[i]) || (claim && vid == i)) np[i] = 1'b0;
        else np[i] = m_pend[i];
      end else begin
        np[i] = IRQ[i];
      end
      if (bus_if.WE && off == 3'd1 && bus_if.Din[i] && !m_mode[i]) np[i] = 1'b0;
    end
    if (claim && vid >= 0) m_insvc[vid] = 1'b1;
    eid = int'(bus_if.Din[2:0]);
    if (eoi && eid < 6) m_insvc[eid] = 1'b0;
    m_hw = e;
    if (bus_if.WE && off == 3'd0) m_mask = bus_if.Din[5:0];
    if (bus_if.WE && off == 3'd1) m_mode = bus_if.Din[5:0];
    m_pend = np;
    m_irqq = IRQ;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("hwint_model", {26'd0, HWInt}, {26'd0, m_hw});
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_if.Addr = a; bus_if.WE = 1'b1; bus_if.Din = d;
    tick();
    bus_if.WE = 1'b0; bus_if.Din = '0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus_if.Addr = a; bus_if.WE = 1'b0;
    #1;
    chk(tag, bus_if.Dout, exp);
  endtask

  task automatic hw(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, HWInt}, {26'd0, exp});
  endtask

  initial begin
    reset = 1'b1; IRQ = '0;
    bus_if.Addr = '0; bus_if.WE = 1'b0; bus_if.Din = '0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    rd("rst_mask", 8'h00, 0); rd("rst_mode", 8'h04, 0); rd("rst_pend", 8'h08, 0);
    rd("rst_vec", 8'h0C, 0);  rd("rst_insvc", 8'h10, 0);
    hw("rst_hw", 6'h00);

    // Edge latency and W1C with IRQ held
    wr(8'h00, 32'h3F); wr(8'h04, 32'h01);
    IRQ = 6'h01;
    tick();
    rd("edge_pend", 8'h08, 32'h01); hw("edge_hw_e1", 6'h00);
    tick();
    hw("edge_hw_e2", 6'h01);
    wr(8'h08, 32'h01);
    rd("edge_w1c", 8'h08, 32'h00);
    tick();
    rd("edge_no_repend", 8'h08, 32'h00); hw("edge_hw_off", 6'h00);
    IRQ = '0;

    // Level mode and masking
    wr(8'h04, 32'h00); wr(8'h00, 32'h00);
    IRQ = 6'h08;
    tick();
    rd("lvl_pend", 8'h08, 32'h08); hw("lvl_masked", 6'h00);
    wr(8'h00, 32'h08);
    tick();
    hw("lvl_unmask", 6'h08);
    IRQ = '0;
    tick(); tick();
    hw("lvl_drop", 6'h00);

    // Nesting
    wr(8'h00, 32'h3F); wr(8'h04, 32'h3F);
    IRQ = 6'h14; tick(); IRQ = '0; tick();
    rd("nest_pend", 8'h08, 32'h14);
    rd("nest_vec", 8'h0C, 32'h8000_0002);
    wr(8'h0C, 32'h8000_0000);
    rd("nest_insvc", 8'h10, 32'h04); rd("nest_pend_claim", 8'h08, 32'h10);
    tick();
    hw("nest_blocked", 6'h00);
    IRQ = 6'h02; tick(); IRQ = '0; tick();
    hw("nest_preempt", 6'h02);
    wr(8'h0C, 32'h0000_0002);
    tick();
    hw("nest_eoi", 6'h12);
    wr(8'h08, 32'h3F); tick();

    // Same-edge set and clear; ignored EOI / empty CLAIM
    IRQ = 6'h20;
    wr(8'h08, 32'h20);
    IRQ = '0;
    rd("set_wins", 8'h08, 32'h20);
    wr(8'h0C, 32'h8000_0000);
    rd("claim5", 8'h10, 32'h20);
    wr(8'h0C, 32'h0000_0007);
    rd("eoi_id7", 8'h10, 32'h20);
    wr(8'h0C, 32'h8000_0000);
    rd("claim_novalid", 8'h10, 32'h20);
    wr(8'h0C, 32'h0000_0005);

    // Reset in the middle of service
    IRQ = 6'h01; tick(); IRQ = '0;
    wr(8'h0C, 32'h8000_0000);
    IRQ = 6'h30; tick(); IRQ = '0; tick();
    rd("mid_insvc", 8'h10, 32'h01); rd("mid_pend", 8'h08, 32'h30);
    reset = 1'b1; IRQ = 6'h08;
    tick();
    reset = 1'b0;
    hw("mid_hw", 6'h00);
    rd("mid_mask", 8'h00, 0); rd("mid_mode", 8'h04, 0); rd("mid_pend0", 8'h08, 0);
    rd("mid_vec", 8'h0C, 0);  rd("mid_insvc0", 8'h10, 0);
    IRQ = '0;
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      IRQ = 6'($urandom & $urandom);
      bus_if.Addr = 8'($urandom);
      bus_if.WE = ($urandom_range(0, 2) == 0);
      bus_if.Din = $urandom;
      if ($urandom_range(0, 1) == 0) bus_if.Addr = {3'b000, 3'd3, 2'b00};
      if (bus_if.Addr[4:2] == 3'd0 && $urandom_range(0, 1) == 1) bus_if.Din[5:0] = 6'h3F;
      #1;
      if (!bus_if.WE) chk("rand_dout", bus_if.Dout, m_read(bus_if.Addr));
      tick();
    end
    reset = 1'b0; bus_if.WE = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
